arm_dcache_controller: RTL and testbench

Two-way set-associative, write-through, read-allocate data cache controller that sits between the MEM stage and the SRAM controller of the pipelined ARM core. It serves load hits in zero extra cycles and sequences SRAM transactions on load misses and on all stores. While a transaction is pending it holds `ready` low, and the core uses `ready` as its pipeline-wide freeze. It owns the tag, valid, data and LRU arrays.

---
 rtl/arm_dcache_controller_pkg.sv | 25 ++
 rtl/arm_dcache_controller_if.sv | 38 +++
 rtl/arm_dcache_controller_storage.sv | 85 ++++++++
 rtl/arm_dcache_controller.sv | 128 ++++++++++++
 tb/tb_arm_dcache_controller.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/arm_dcache_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dcache_pkg                                                   |
// | Description : Shared constants for the ARM data cache controller: field   |
// |               widths, address slice positions and FSM state encodings.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package dcache_pkg;

  // Address layout: [1:0] byte, [2] word in line, [8:3] index, [18:9] tag
  localparam int TAG_W    = 10;
  localparam int IDX_W    = 6;
  localparam int LINE_W   = 64;
  localparam int WORD_W   = 32;
  localparam int WORD_BIT = 2;
  localparam int IDX_LSB  = 3;
  localparam int TAG_LSB  = IDX_LSB + IDX_W;

  // Controller states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_MISS = 2'd1;
  localparam logic [1:0] ST_WR_THRU = 2'd2;

endpackage : dcache_pkg
`default_nettype wire

// File: rtl/arm_dcache_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arm_dcache_controller_if                                    |
// | Description : Bundles the MEM-stage request/response and the SRAM         |
// |               controller transaction signals of the data cache.           |
// |               master : core + SRAM controller side                        |
// |               slave  : cache controller side                              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface arm_dcache_controller_if;

  // MEM stage side
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  // SRAM controller side
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  modport master (
    output rd_en, wr_en, address, wdata, sram_rdata, sram_ready,
    input  rdata, ready, sram_rd_en, sram_wr_en, sram_address, sram_wdata
  );

  modport slave (
    input  rd_en, wr_en, address, wdata, sram_rdata, sram_ready,
    output rdata, ready, sram_rd_en, sram_wr_en, sram_address, sram_wdata
  );

endinterface : arm_dcache_controller_if
`default_nettype wire

// File: rtl/arm_dcache_controller_storage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dcache_storage                                               |
// | Description : Two-way tag/valid/data arrays plus per-set LRU bit.         |
// |               Ports: index/tag/word_sel lookup -> hit, hit_way, rd_word,   |
// |               lru_way (combinational); fill_* writes a whole line with    |
// |               tag and valid; upd_* writes one word of a way; lru_upd_*     |
// |               writes the LRU bit. Valid and LRU reset asynchronously.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dcache_storage #(
  parameter int SETS  = 64,
  parameter int TAG_W = 10,
  parameter int IDX_W = $clog2(SETS)
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic [IDX_W-1:0]           index,
  input  wire logic [TAG_W-1:0]           tag,
  input  wire logic                       word_sel,
  output logic                            hit,
  output logic                            hit_way,
  output logic [31:0]                     rd_word,
  output logic                            lru_way,
  input  wire logic                       fill_en,
  input  wire logic                       fill_way,
  input  wire logic [63:0]                fill_data,
  input  wire logic                       upd_en,
  input  wire logic                       upd_way,
  input  wire logic [31:0]                upd_word,
  input  wire logic                       lru_upd_en,
  input  wire logic                       lru_upd_val
);
  import dcache_pkg::*;

  logic [1:0]        hit_w;
  logic [LINE_W-1:0] line_w [2];
  logic [SETS-1:0]   lru_q;
  logic [LINE_W-1:0] line_sel;

  for (genvar w = 0; w < 2; w++) begin : g_way
    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= '0;
      end else if (fill_en && (fill_way == 1'(w))) begin
        valid_q[index] <= 1'b1;
      end
    end

    // Tag and data carry no reset; a line is meaningless until valid is set
    always_ff @(posedge clk) begin
      if (fill_en && (fill_way == 1'(w))) begin
        tag_q[index]  <= tag;
        data_q[index] <= fill_data;
      end else if (upd_en && (upd_way == 1'(w))) begin
        if (word_sel) data_q[index][63:32] <= upd_word;
        else          data_q[index][31:0]  <= upd_word;
      end
    end

    assign hit_w[w]  = valid_q[index] && (tag_q[index] == tag);
    assign line_w[w] = data_q[index];
  end : g_way

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lru_q <= '0;
    end else if (lru_upd_en) begin
      lru_q[index] <= lru_upd_val;
    end
  end

  // At most one way can hit, so the way-1 hit bit doubles as the way index
  assign hit      = |hit_w;
  assign hit_way  = hit_w[1];
  assign line_sel = hit_w[1] ? line_w[1] : line_w[0];
  assign rd_word  = word_sel ? line_sel[63:32] : line_sel[31:0];
  assign lru_way  = lru_q[index];

endmodule : dcache_storage
`default_nettype wire

// File: rtl/arm_dcache_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arm_dcache_controller                                       |
// | Description : Two-way, write-through, read-allocate data cache FSM.       |
// |               Ports: clk, rst (async, active high), bus (slave modport   |
// |               carrying the MEM-stage request and SRAM transaction).       |
// |               Load hits complete in the request cycle; load misses and   |
// |               all stores hold ready low until sram_ready.                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module arm_dcache_controller #(
  parameter int SETS  = 64,
  parameter int TAG_W = 10
) (
  input  wire logic             clk,
  input  wire logic             rst,
  arm_dcache_controller_if.slave bus
);
  import dcache_pkg::*;

  localparam int IX_W = $clog2(SETS);
  localparam int TG_L = IDX_LSB + IX_W;

  logic [1:0]      state_q, state_d;
  logic [IX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic            word_sel;
  logic            hit, hit_way, lru_way;
  logic [31:0]     hit_word;
  logic            fill_en, upd_en, lru_upd_en, lru_upd_val;

  assign index    = bus.address[IDX_LSB +: IX_W];
  assign tag      = bus.address[TG_L +: TAG_W];
  assign word_sel = bus.address[WORD_BIT];

  dcache_storage #(
    .SETS  (SETS),
    .TAG_W (TAG_W),
    .IDX_W (IX_W)
  ) u_storage (
    .clk         (clk),
    .rst         (rst),
    .index       (index),
    .tag         (tag),
    .word_sel    (word_sel),
    .hit         (hit),
    .hit_way     (hit_way),
    .rd_word     (hit_word),
    .lru_way     (lru_way),
    .fill_en     (fill_en),
    .fill_way    (lru_way),
    .fill_data   (bus.sram_rdata),
    .upd_en      (upd_en),
    .upd_way     (hit_way),
    .upd_word    (bus.wdata),
    .lru_upd_en  (lru_upd_en),
    .lru_upd_val (lru_upd_val)
  );

  always_comb begin
    state_d         = state_q;
    bus.ready       = 1'b1;
    bus.rdata       = '0;
    bus.sram_rd_en  = 1'b0;
    bus.sram_wr_en  = 1'b0;
    fill_en         = 1'b0;
    upd_en          = 1'b0;
    lru_upd_en      = 1'b0;
    lru_upd_val     = 1'b0;

    if (rst) begin
      // Reset holds the state in IDLE; any pending request just stalls
      bus.ready = ~(bus.rd_en | bus.wr_en);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.wr_en) begin
            // Store wins over a simultaneous load; hits update in place
            bus.sram_wr_en = 1'b1;
            bus.ready      = 1'b0;
            state_d        = ST_WR_THRU;
            upd_en         = hit;
            lru_upd_en     = hit;
            lru_upd_val    = ~hit_way;
          end else if (bus.rd_en) begin
            if (hit) begin
              bus.rdata   = hit_word;
              lru_upd_en  = 1'b1;
              lru_upd_val = ~hit_way;
            end else begin
              bus.sram_rd_en = 1'b1;
              bus.ready      = 1'b0;
              state_d        = ST_RD_MISS;
            end
          end
        end
        ST_RD_MISS: begin
          bus.sram_rd_en = 1'b1;
          bus.ready      = bus.sram_ready;
          if (bus.sram_ready) begin
            bus.rdata   = word_sel ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
            fill_en     = 1'b1;
            lru_upd_en  = 1'b1;
            lru_upd_val = ~lru_way;
            state_d     = ST_IDLE;
          end
        end
        ST_WR_THRU: begin
          bus.sram_wr_en = 1'b1;
          bus.ready      = bus.sram_ready;
          if (bus.sram_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Line reads are always line aligned; word writes keep the full address
  assign bus.sram_address = bus.sram_wr_en ? bus.address : {bus.address[31:3], 3'b000};
  assign bus.sram_wdata   = bus.wdata;

endmodule : arm_dcache_controller
`default_nettype wire

// File: tb/tb_arm_dcache_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_arm_dcache_controller                                    |
// | Description : Directed self-checking bench for arm_dcache_controller.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_arm_dcache_controller;
  import dcache_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  arm_dcache_controller_if bus ();

  arm_dcache_controller #(.SETS(64), .TAG_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        first_ready;
    logic [31:0] first_rdata;
    logic        first_srd;
    logic        first_swr;
    logic [31:0] first_saddr;
    logic [31:0] first_swdata;
    logic        held;
    logic        end_ready;
    logic [31:0] end_rdata;
  } obs_t;

  // Drives one request; if it stalls, answers it with sram_ready on the
  // lat-th cycle after the request cycle and records what the DUT showed.
  task automatic xact(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [63:0] line,
                      input int lat, output obs_t o);
    @(posedge clk); #1;
    bus.rd_en = rd; bus.wr_en = wr; bus.address = a; bus.wdata = wd;
    @(negedge clk);
    o.first_ready  = bus.ready;
    o.first_rdata  = bus.rdata;
    o.first_srd    = bus.sram_rd_en;
    o.first_swr    = bus.sram_wr_en;
    o.first_saddr  = bus.sram_address;
    o.first_swdata = bus.sram_wdata;
    o.held         = 1'b1;
    o.end_ready    = bus.ready;
    o.end_rdata    = bus.rdata;
    if (bus.ready !== 1'b1) begin
      for (int i = 1; i <= lat; i++) begin
        @(posedge clk); #1;
        if (i == lat) begin
          bus.sram_ready = 1'b1;
          bus.sram_rdata = line;
        end
        @(negedge clk);
        if ((bus.sram_rd_en | bus.sram_wr_en) !== 1'b1) o.held = 1'b0;
        if (i < lat && bus.ready !== 1'b0) o.held = 1'b0;
        o.end_ready = bus.ready;
        o.end_rdata = bus.rdata;
      end
    end
    @(posedge clk); #1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.sram_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.address = '0; bus.wdata = '0;
    bus.sram_rdata = '0; bus.sram_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0h want=1", bus.ready); end
    checks++; if ({bus.sram_rd_en, bus.sram_wr_en} !== 2'b00) begin failures++; $display("FAIL rst_sram_en got=%b want=00", {bus.sram_rd_en, bus.sram_wr_en}); end
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h want=0", bus.rdata); end
    bus.rd_en = 1'b1; bus.address = 32'h40;
    #1;
    checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%0h want=0", bus.ready); end
    checks++; if (bus.sram_rd_en !== 1'b0) begin failures++; $display("FAIL rst_req_srd got=%0h want=0", bus.sram_rd_en); end
    @(posedge clk); #1;
    bus.rd_en = 1'b0; rst = 1'b0;
  endtask

  task automatic test_cold_load();
    obs_t o;
    xact(1'b1, 1'b0, 32'h40, 32'h0, {32'hBBBB_BBBB, 32'hAAAA_AAAA}, 5, o);
    checks++; if (o.first_ready !== 1'b0) begin failures++; $display("FAIL cold_ready got=%0h want=0", o.first_ready); end
    checks++; if (o.first_srd !== 1'b1) begin failures++; $display("FAIL cold_srd got=%0h want=1", o.first_srd); end
    checks++; if (o.first_saddr !== 32'h40) begin failures++; $display("FAIL cold_saddr got=%h want=00000040", o.first_saddr); end
    checks++; if (o.held !== 1'b1) begin failures++; $display("FAIL cold_held got=%0h want=1", o.held); end
    checks++; if (o.end_ready !== 1'b1 || o.end_rdata !== 32'hAAAA_AAAA) begin failures++; $display("FAIL cold_fill_data got=%0h/%h want=1/aaaaaaaa", o.end_ready, o.end_rdata); end
    xact(1'b1, 1'b0, 32'h44, 32'h0, 64'h0, 5, o);
    checks++; if (o.first_ready !== 1'b1 || o.first_rdata !== 32'hBBBB_BBBB) begin failures++; $display("FAIL cold_rehit got=%0h/%h want=1/bbbbbbbb", o.first_ready, o.first_rdata); end
    // Word 1 of index 9: read address must come out line aligned
    xact(1'b1, 1'b0, 32'h4C, 32'h0, {32'hDDDD_DDDD, 32'hCCCC_CCCC}, 3, o);
    checks++; if (o.first_saddr !== 32'h48) begin failures++; $display("FAIL word1_saddr got=%h want=00000048", o.first_saddr); end
    checks++; if (o.end_rdata !== 32'hDDDD_DDDD) begin failures++; $display("FAIL word1_rdata got=%h want=dddddddd", o.end_rdata); end
  endtask

  task automatic test_lru();
    obs_t o;
    xact(1'b1, 1'b0, 32'h240, 32'h0, {32'h2222_0001, 32'h2222_0000}, 2, o);
    checks++; if (o.first_ready !== 1'b0) begin failures++; $display("FAIL lru_240_miss got=%0h want=0", o.first_ready); end
    xact(1'b1, 1'b0, 32'h40, 32'h0, 64'h0, 2, o);
    checks++; if (o.first_ready !== 1'b1 || o.first_rdata !== 32'hAAAA_AAAA) begin failures++; $display("FAIL lru_40_hit got=%0h/%h want=1/aaaaaaaa", o.first_ready, o.first_rdata); end
    xact(1'b1, 1'b0, 32'h440, 32'h0, {32'h4444_0001, 32'h4444_0000}, 2, o);
    checks++; if (o.first_ready !== 1'b0 || o.end_rdata !== 32'h4444_0000) begin failures++; $display("FAIL lru_440_miss got=%0h/%h want=0/44440000", o.first_ready, o.end_rdata); end
    xact(1'b1, 1'b0, 32'h40, 32'h0, 64'h0, 2, o);
    checks++; if (o.first_ready !== 1'b1 || o.first_rdata !== 32'hAAAA_AAAA) begin failures++; $display("FAIL lru_40_kept got=%0h/%h want=1/aaaaaaaa", o.first_ready, o.first_rdata); end
    xact(1'b1, 1'b0, 32'h240, 32'h0, {32'h2222_0001, 32'h2222_0000}, 2, o);
    checks++; if (o.first_ready !== 1'b0) begin failures++; $display("FAIL lru_240_evicted got=%0h want=0", o.first_ready); end
  endtask

  task automatic test_store_hit();
    obs_t o;
    xact(1'b0, 1'b1, 32'h44, 32'h1234_5678, 64'h0, 4, o);
    checks++; if ({o.first_swr, o.first_srd, o.first_ready} !== 3'b100) begin failures++; $display("FAIL st_en got=%b want=100", {o.first_swr, o.first_srd, o.first_ready}); end
    checks++; if (o.first_saddr !== 32'h44 || o.first_swdata !== 32'h1234_5678) begin failures++; $display("FAIL st_bus got=%h/%h want=00000044/12345678", o.first_saddr, o.first_swdata); end
    checks++; if (o.held !== 1'b1 || o.end_ready !== 1'b1) begin failures++; $display("FAIL st_held got=%0h/%0h want=1/1", o.held, o.end_ready); end
    xact(1'b1, 1'b0, 32'h44, 32'h0, 64'h0, 2, o);
    checks++; if (o.first_ready !== 1'b1 || o.first_rdata !== 32'h1234_5678) begin failures++; $display("FAIL st_reload got=%0h/%h want=1/12345678", o.first_ready, o.first_rdata); end
    xact(1'b1, 1'b0, 32'h40, 32'h0, 64'h0, 2, o);
    checks++; if (o.first_ready !== 1'b1 || o.first_rdata !== 32'hAAAA_AAAA) begin failures++; $display("FAIL st_other_word got=%0h/%h want=1/aaaaaaaa", o.first_ready, o.first_rdata); end
  endtask

  task automatic test_store_miss();
    obs_t o;
    xact(1'b0, 1'b1, 32'h800, 32'h5555_AAAA, 64'h0, 3, o);
    checks++; if (o.first_swr !== 1'b1 || o.first_saddr !== 32'h800 || o.end_ready !== 1'b1) begin failures++; $display("FAIL stm_write got=%0h/%h/%0h want=1/00000800/1", o.first_swr, o.first_saddr, o.end_ready); end
    xact(1'b1, 1'b0, 32'h800, 32'h0, {32'h0, 32'h5555_AAAA}, 2, o);
    checks++; if (o.first_ready !== 1'b0) begin failures++; $display("FAIL stm_no_alloc got=%0h want=0", o.first_ready); end
  endtask

  task automatic test_rd_wr_both();
    @(posedge clk); #1;
    bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.address = 32'h40; bus.wdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if ({bus.sram_wr_en, bus.sram_rd_en} !== 2'b10) begin failures++; $display("FAIL both_en got=%b want=10", {bus.sram_wr_en, bus.sram_rd_en}); end
    @(posedge clk); #1;
    checks++; if (dut.state_q !== ST_WR_THRU) begin failures++; $display("FAIL both_state got=%0d want=%0d", dut.state_q, ST_WR_THRU); end
    bus.sram_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.ready !== 1'b1 || bus.sram_rd_en !== 1'b0) begin failures++; $display("FAIL both_done got=%0h/%0h want=1/0", bus.ready, bus.sram_rd_en); end
    @(posedge clk); #1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.sram_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    xact(1'b1, 1'b0, 32'h40, 32'h0, 64'h0, 2, o);
    checks++; if (o.first_ready !== 1'b1 || o.first_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL rm_prehit got=%0h/%h want=1/cafef00d", o.first_ready, o.first_rdata); end
    @(posedge clk); #1;
    bus.rd_en = 1'b1; bus.address = 32'hC40;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.sram_rd_en !== 1'b1) begin failures++; $display("FAIL rm_pending got=%0h want=1", bus.sram_rd_en); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.sram_rd_en !== 1'b0 || bus.ready !== 1'b0) begin failures++; $display("FAIL rm_drop got=%0h/%0h want=0/0", bus.sram_rd_en, bus.ready); end
    @(posedge clk); #1;
    rst = 1'b0; bus.rd_en = 1'b0;
    xact(1'b1, 1'b0, 32'h40, 32'h0, {32'hBBBB_BBBB, 32'hAAAA_AAAA}, 2, o);
    checks++; if (o.first_ready !== 1'b0 || o.end_rdata !== 32'hAAAA_AAAA) begin failures++; $display("FAIL rm_cleared got=%0h/%h want=0/aaaaaaaa", o.first_ready, o.end_rdata); end
  endtask

  task automatic test_sram_ready_idle();
    @(posedge clk); #1;
    bus.sram_ready = 1'b1;
    @(negedge clk);
    checks++; if ({bus.ready, bus.sram_rd_en, bus.sram_wr_en} !== 3'b100) begin failures++; $display("FAIL idle_pulse got=%b want=100", {bus.ready, bus.sram_rd_en, bus.sram_wr_en}); end
    @(posedge clk); #1;
    bus.sram_ready = 1'b0;
    checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL idle_state got=%0d want=%0d", dut.state_q, ST_IDLE); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_cold_load();
    test_lru();
    test_store_hit();
    test_store_miss();
    test_rd_wr_both();
    test_reset_mid();
    test_sram_ready_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_arm_dcache_controller
`default_nettype wire
